ring_arbiter: RTL and testbench

Round-robin arbiter between the supercore ring request ports and the shared L3 memory read port. Each requester holds a request and address until it receives a one-cycle ready pulse with data or an error flag. The arbiter range-checks every address against the L3 window and never presents an out-of-range address to memory. It sits between the supercore ring ports and the `mem` instance in the CPU top level, and replaces ad-hoc fixed-priority granting.

---
 rtl/ember_ring_pkg.sv | 23 ++
 rtl/rr_picker.sv | 44 ++++
 rtl/ring_arbiter.sv | 162 ++++++++++++++++
 tb/tb_ring_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ember_ring_pkg.sv
// ---------------------------------------------------------------------------
// ember_ring_pkg
// Shared definitions for the supercore ring stops: arbiter state encoding,
// the default L3 window and the width/default of the memory timeout counter.
// No ports (package).
// ---------------------------------------------------------------------------
package ember_ring_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    // Default L3 window: [L3_BASE_DEF, L3_BASE_DEF + L3_SIZE_DEF)
    localparam logic [63:0] L3_BASE_DEF = 64'd0;
    localparam logic [63:0] L3_SIZE_DEF = 64'd4194304;

    // Memory completion timeout is tracked by an 8-bit counter.
    localparam int TMO_W       = 8;
    localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin pick: rotates the request vector so that the
// pointer position becomes bit 0, then takes the lowest set bit. The returned
// index is in un-rotated (requester) numbering.
//   req   in  N     request bits
//   ptr   in  PW    highest-priority requester index (must be < N)
//   grant out PW    chosen requester index (0 when valid is low)
//   valid out 1     at least one request was set
// ---------------------------------------------------------------------------
module rr_picker #(
    parameter int N = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] grant,
    output logic          valid
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [PW:0]    sum;

    always_comb begin
        // Doubling the vector lets a plain right shift act as a rotate.
        dbl   = {req, req} >> ptr;
        rot   = dbl[N-1:0];
        grant = '0;
        valid = 1'b0;
        sum   = '0;
        for (int i = 0; i < N; i++) begin
            if (!valid && rot[i]) begin
                valid = 1'b1;
                sum   = {1'b0, ptr} + (PW+1)'(i);
                if (sum >= (PW+1)'(N)) begin
                    sum = sum - (PW+1)'(N);
                end
                grant = sum[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/ring_arbiter.sv
// ---------------------------------------------------------------------------
// ring_arbiter
// Round-robin arbiter between the supercore ring request ports and the shared
// L3 memory read port. Out-of-range addresses are answered with an error and
// never reach memory; a memory read that does not complete within TIMEOUT
// cycles is answered with an error.
//
// Handshake: a requester raises ring_req[i] with a stable ring_addr slice and
// holds both until it samples ring_ready[i] high (one-cycle pulse, at most one
// bit set). ring_err[i] and ring_rdata qualify that pulse. On the memory side
// mem_rd_en is a level held with a stable mem_addr until mem_rd_done pulses;
// mem_rd_data is taken in the cycle mem_rd_done is high.
//
//   clk          in   1                rising-edge clock
//   rst          in   1                asynchronous active-high reset
//   ring_req     in   NUM_REQ          per-requester request level
//   ring_addr    in   NUM_REQ*ADDR_W   requester i at [i*ADDR_W +: ADDR_W]
//   ring_ready   out  NUM_REQ          one-cycle response pulse
//   ring_err     out  NUM_REQ          error qualifier for ring_ready
//   ring_rdata   out  DATA_W           response data (0 on error)
//   mem_rd_en    out  1                memory read enable (level)
//   mem_addr     out  ADDR_W           memory read address
//   mem_rd_data  in   DATA_W           memory read data
//   mem_rd_done  in   1                memory completion pulse
// ---------------------------------------------------------------------------
module ring_arbiter
    import ember_ring_pkg::*;
#(
    parameter int          NUM_REQ = 2,
    parameter int          ADDR_W  = 64,
    parameter int          DATA_W  = 64,
    parameter logic [63:0] L3_BASE = L3_BASE_DEF,
    parameter logic [63:0] L3_SIZE = L3_SIZE_DEF,
    parameter int          TIMEOUT = TIMEOUT_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        ring_req,
    input  logic [NUM_REQ*ADDR_W-1:0] ring_addr,
    output logic [NUM_REQ-1:0]        ring_ready,
    output logic [NUM_REQ-1:0]        ring_err,
    output logic [DATA_W-1:0]         ring_rdata,
    output logic                      mem_rd_en,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic [DATA_W-1:0]         mem_rd_data,
    input  logic                      mem_rd_done
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Window bounds widened by one bit so base+size never wraps.
    localparam logic [ADDR_W:0] BASE_X    = {1'b0, ADDR_W'(L3_BASE)};
    localparam logic [ADDR_W:0] SIZE_X    = (ADDR_W+1)'(L3_SIZE);
    localparam logic [TMO_W:0]  TMO_LIMIT = (TMO_W+1)'(TIMEOUT);

    arb_state_t          state;
    logic [PTR_W-1:0]    ptr;
    logic [PTR_W-1:0]    grant_q;
    logic                err_q;
    logic [TMO_W-1:0]    tmo_cnt;

    logic [NUM_REQ-1:0]  req_eff;
    logic [PTR_W-1:0]    pick_grant;
    logic                pick_valid;
    logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
    logic [ADDR_W-1:0]   pick_addr;
    logic [ADDR_W:0]     addr_x;
    logic [ADDR_W:0]     offset_x;
    logic                in_range;
    logic [NUM_REQ-1:0]  grant_onehot;

    // The requester just answered still holds req during its ready cycle
    // (it drops on the following edge), so it is masked to avoid a re-grant.
    assign req_eff = ring_req & ~ring_ready;

    rr_picker #(
        .N (NUM_REQ)
    ) u_picker (
        .req   (req_eff),
        .ptr   (ptr),
        .grant (pick_grant),
        .valid (pick_valid)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr[i] = ring_addr[i*ADDR_W +: ADDR_W];
        end
    end

    assign pick_addr = addr_arr[pick_grant];

    always_comb begin
        addr_x   = {1'b0, pick_addr};
        offset_x = addr_x - BASE_X;
        // offset_x is only meaningful once addr >= base has been established.
        in_range = (addr_x >= BASE_X) && (offset_x < SIZE_X);
    end

    assign grant_onehot = NUM_REQ'(1) << grant_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            grant_q    <= '0;
            err_q      <= 1'b0;
            tmo_cnt    <= '0;
            ring_ready <= '0;
            ring_err   <= '0;
            ring_rdata <= '0;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
        end else begin
            ring_ready <= '0;
            ring_err   <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant_q <= pick_grant;
                        tmo_cnt <= '0;
                        if (in_range) begin
                            mem_rd_en <= 1'b1;
                            mem_addr  <= pick_addr;
                            state     <= ST_WAIT;
                        end else begin
                            err_q      <= 1'b1;
                            ring_rdata <= '0;
                            state      <= ST_RESP;
                        end
                    end
                end
                ST_WAIT: begin
                    if (mem_rd_done) begin
                        ring_rdata <= mem_rd_data;
                        err_q      <= 1'b0;
                        mem_rd_en  <= 1'b0;
                        state      <= ST_RESP;
                    end else if (({1'b0, tmo_cnt} + 1'b1) >= TMO_LIMIT) begin
                        // TIMEOUT waiting cycles have now elapsed.
                        ring_rdata <= '0;
                        err_q      <= 1'b1;
                        mem_rd_en  <= 1'b0;
                        state      <= ST_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    ring_ready <= grant_onehot;
                    ring_err   <= err_q ? grant_onehot : '0;
                    ptr        <= (grant_q == PTR_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                    state      <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ring_arbiter.sv
module tb_ring_arbiter;

    logic         clk = 1'b0;
    logic         rst;

    logic [1:0]   ring_req;
    logic [127:0] ring_addr;
    logic [1:0]   ring_ready;
    logic [1:0]   ring_err;
    logic [63:0]  ring_rdata;
    logic         mem_rd_en;
    logic [63:0]  mem_addr;
    logic [63:0]  mem_rd_data;
    logic         mem_rd_done;

    logic [1:0]   b_req;
    logic [127:0] b_addr;
    logic [1:0]   b_ready;
    logic [1:0]   b_err;
    logic [63:0]  b_rdata;
    logic         b_mem_rd_en;
    logic [63:0]  b_mem_addr;
    logic [63:0]  b_mem_rd_data;
    logic         b_mem_rd_done;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ring_arbiter #(
        .NUM_REQ (2), .ADDR_W (64), .DATA_W (64),
        .L3_BASE (64'd0), .L3_SIZE (64'd4194304), .TIMEOUT (4)
    ) u_dut (
        .clk (clk), .rst (rst),
        .ring_req (ring_req), .ring_addr (ring_addr),
        .ring_ready (ring_ready), .ring_err (ring_err), .ring_rdata (ring_rdata),
        .mem_rd_en (mem_rd_en), .mem_addr (mem_addr),
        .mem_rd_data (mem_rd_data), .mem_rd_done (mem_rd_done)
    );

    ring_arbiter #(
        .NUM_REQ (2), .ADDR_W (64), .DATA_W (64),
        .L3_BASE (64'h1000), .L3_SIZE (64'd4194304), .TIMEOUT (4)
    ) u_dut_b (
        .clk (clk), .rst (rst),
        .ring_req (b_req), .ring_addr (b_addr),
        .ring_ready (b_ready), .ring_err (b_err), .ring_rdata (b_rdata),
        .mem_rd_en (b_mem_rd_en), .mem_addr (b_mem_addr),
        .mem_rd_data (b_mem_rd_data), .mem_rd_done (b_mem_rd_done)
    );

    // Driver for u_dut: raises one request, plays a memory that answers after
    // lat cycles of mem_rd_en (lat < 0: never), waits (bounded) for the ready
    // pulse, drops the request and samples one more cycle.
    task automatic do_req(input int idx, input logic [63:0] addr, input int lat,
                          input logic [63:0] data,
                          output logic saw_en, output logic [63:0] en_addr,
                          output logic [1:0] rdy, output logic [1:0] err,
                          output logic [63:0] rdat, output int cyc,
                          output logic en_at_rdy, output logic [1:0] rdy_after);
        int en_cnt;
        en_cnt  = 0;
        saw_en  = 1'b0;
        en_addr = '0;
        rdy     = '0;
        err     = '0;
        rdat    = '0;
        cyc     = 0;
        en_at_rdy = 1'b0;
        ring_addr[idx*64 +: 64] = addr;
        ring_req[idx] = 1'b1;
        while (rdy == 2'b00 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            mem_rd_done = 1'b0;
            if (ring_ready != 2'b00) begin
                rdy       = ring_ready;
                err       = ring_err;
                rdat      = ring_rdata;
                en_at_rdy = mem_rd_en;
            end else if (mem_rd_en) begin
                if (!saw_en) begin
                    saw_en  = 1'b1;
                    en_addr = mem_addr;
                end
                en_cnt++;
                if (lat >= 0 && en_cnt == lat) begin
                    mem_rd_done = 1'b1;
                    mem_rd_data = data;
                end
            end
        end
        ring_req[idx] = 1'b0;
        @(negedge clk);
        rdy_after = ring_ready;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ring_req = '0; ring_addr = '0; mem_rd_data = '0; mem_rd_done = 1'b0;
        b_req = '0; b_addr = '0; b_mem_rd_data = '0; b_mem_rd_done = 1'b0;
        #3;
        n_checks++; if (ring_ready !== 2'b00) $display("FAIL reset_ready: got %h exp 0", ring_ready); else n_pass++;
        n_checks++; if (ring_err !== 2'b00) $display("FAIL reset_err: got %h exp 0", ring_err); else n_pass++;
        n_checks++; if (ring_rdata !== 64'h0) $display("FAIL reset_rdata: got %h exp 0", ring_rdata); else n_pass++;
        n_checks++; if (mem_rd_en !== 1'b0) $display("FAIL reset_rd_en: got %h exp 0", mem_rd_en); else n_pass++;
        n_checks++; if (mem_addr !== 64'h0) $display("FAIL reset_mem_addr: got %h exp 0", mem_addr); else n_pass++;
        n_checks++; if (b_mem_rd_en !== 1'b0) $display("FAIL reset_b_rd_en: got %h exp 0", b_mem_rd_en); else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic saw_en, en_at_rdy;
        logic [63:0] en_addr, rdat;
        logic [1:0] rdy, err, rdy_after;
        int cyc;
        do_req(0, 64'h100, 2, 64'hDEAD, saw_en, en_addr, rdy, err, rdat, cyc, en_at_rdy, rdy_after);
        n_checks++; if (saw_en !== 1'b1) $display("FAIL single_rd_en: got %h exp 1", saw_en); else n_pass++;
        n_checks++; if (en_addr !== 64'h100) $display("FAIL single_mem_addr: got %h exp 100", en_addr); else n_pass++;
        n_checks++; if (rdy !== 2'b01) $display("FAIL single_ready: got %b exp 01", rdy); else n_pass++;
        n_checks++; if (err !== 2'b00) $display("FAIL single_err: got %b exp 00", err); else n_pass++;
        n_checks++; if (rdat !== 64'hDEAD) $display("FAIL single_rdata: got %h exp dead", rdat); else n_pass++;
        n_checks++; if (cyc !== 4) $display("FAIL single_latency: got %0d exp 4", cyc); else n_pass++;
        n_checks++; if (rdy_after !== 2'b00) $display("FAIL single_one_pulse: got %b exp 00", rdy_after); else n_pass++;
        // 1-cycle memory gives the minimum 3-edge latency.
        do_req(1, 64'h180, 1, 64'hCAFE, saw_en, en_addr, rdy, err, rdat, cyc, en_at_rdy, rdy_after);
        n_checks++; if (rdy !== 2'b10) $display("FAIL minlat_ready: got %b exp 10", rdy); else n_pass++;
        n_checks++; if (rdat !== 64'hCAFE) $display("FAIL minlat_rdata: got %h exp cafe", rdat); else n_pass++;
        n_checks++; if (cyc !== 3) $display("FAIL minlat_latency: got %0d exp 3", cyc); else n_pass++;
    endtask

    task automatic test_out_of_range();
        logic saw_en, en_at_rdy;
        logic [63:0] en_addr, rdat;
        logic [1:0] rdy, err, rdy_after;
        int cyc;
        do_req(1, 64'h400000, 1, 64'h5555, saw_en, en_addr, rdy, err, rdat, cyc, en_at_rdy, rdy_after);
        n_checks++; if (saw_en !== 1'b0) $display("FAIL oor_rd_en: got %h exp 0", saw_en); else n_pass++;
        n_checks++; if (rdy !== 2'b10) $display("FAIL oor_ready: got %b exp 10", rdy); else n_pass++;
        n_checks++; if (err !== 2'b10) $display("FAIL oor_err: got %b exp 10", err); else n_pass++;
        n_checks++; if (rdat !== 64'h0) $display("FAIL oor_rdata: got %h exp 0", rdat); else n_pass++;
        n_checks++; if (cyc !== 2) $display("FAIL oor_latency: got %0d exp 2", cyc); else n_pass++;
    endtask

    task automatic test_contention();
        logic [1:0]  exp_rdy;
        logic [63:0] exp_addr;
        logic        pulsed, got;
        int          cyc;
        ring_addr[63:0]   = 64'h200;
        ring_addr[127:64] = 64'h300;
        ring_req = 2'b11;
        for (int k = 0; k < 6; k++) begin
            exp_rdy  = (k % 2 == 1) ? 2'b10 : 2'b01;
            exp_addr = (k % 2 == 1) ? 64'h300 : 64'h200;
            pulsed = 1'b0;
            got    = 1'b0;
            cyc    = 0;
            while (!got && cyc < 20) begin
                @(negedge clk);
                cyc++;
                mem_rd_done = 1'b0;
                if (ring_ready != 2'b00) begin
                    got = 1'b1;
                    n_checks++; if (ring_ready !== exp_rdy) $display("FAIL contend_grant%0d: got %b exp %b", k, ring_ready, exp_rdy); else n_pass++;
                    n_checks++; if (ring_rdata !== 64'hA000 + 64'(k)) $display("FAIL contend_rdata%0d: got %h exp %h", k, ring_rdata, 64'hA000 + 64'(k)); else n_pass++;
                end else if (mem_rd_en && !pulsed) begin
                    pulsed = 1'b1;
                    n_checks++; if (mem_addr !== exp_addr) $display("FAIL contend_addr%0d: got %h exp %h", k, mem_addr, exp_addr); else n_pass++;
                    mem_rd_done = 1'b1;
                    mem_rd_data = 64'hA000 + 64'(k);
                end
            end
            if (!got) begin
                n_checks++;
                $display("FAIL contend_timeout%0d: got no ready exp %b", k, exp_rdy);
            end
        end
        ring_req = 2'b00;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_timeout();
        logic saw_en, en_at_rdy;
        logic [63:0] en_addr, rdat;
        logic [1:0] rdy, err, rdy_after;
        int cyc;
        do_req(0, 64'h40, -1, 64'h0, saw_en, en_addr, rdy, err, rdat, cyc, en_at_rdy, rdy_after);
        n_checks++; if (saw_en !== 1'b1) $display("FAIL tmo_rd_en: got %h exp 1", saw_en); else n_pass++;
        n_checks++; if (en_addr !== 64'h40) $display("FAIL tmo_mem_addr: got %h exp 40", en_addr); else n_pass++;
        n_checks++; if (rdy !== 2'b01) $display("FAIL tmo_ready: got %b exp 01", rdy); else n_pass++;
        n_checks++; if (err !== 2'b01) $display("FAIL tmo_err: got %b exp 01", err); else n_pass++;
        n_checks++; if (rdat !== 64'h0) $display("FAIL tmo_rdata: got %h exp 0", rdat); else n_pass++;
        n_checks++; if (cyc !== 6) $display("FAIL tmo_latency: got %0d exp 6", cyc); else n_pass++;
        n_checks++; if (en_at_rdy !== 1'b0) $display("FAIL tmo_rd_en_low: got %h exp 0", en_at_rdy); else n_pass++;
    endtask

    task automatic test_reset_in_wait();
        ring_addr[127:64] = 64'h500;
        ring_req = 2'b10;
        @(negedge clk);
        n_checks++; if (mem_rd_en !== 1'b1) $display("FAIL rstw_rd_en: got %h exp 1", mem_rd_en); else n_pass++;
        n_checks++; if (mem_addr !== 64'h500) $display("FAIL rstw_mem_addr: got %h exp 500", mem_addr); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++; if (mem_rd_en !== 1'b0) $display("FAIL rstw_async_rd_en: got %h exp 0", mem_rd_en); else n_pass++;
        n_checks++; if (mem_addr !== 64'h0) $display("FAIL rstw_async_addr: got %h exp 0", mem_addr); else n_pass++;
        n_checks++; if (ring_ready !== 2'b00) $display("FAIL rstw_async_ready: got %b exp 00", ring_ready); else n_pass++;
        ring_req = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        // Pointer was 1 before reset; with both requesting, grant 0 shows it was cleared.
        ring_addr[63:0]   = 64'h600;
        ring_addr[127:64] = 64'h700;
        ring_req = 2'b11;
        @(negedge clk);
        n_checks++; if (mem_addr !== 64'h600) $display("FAIL rstw_ptr_addr: got %h exp 600", mem_addr); else n_pass++;
        mem_rd_done = 1'b1;
        mem_rd_data = 64'h1234;
        @(negedge clk);
        mem_rd_done = 1'b0;
        @(negedge clk);
        n_checks++; if (ring_ready !== 2'b01) $display("FAIL rstw_ready: got %b exp 01", ring_ready); else n_pass++;
        n_checks++; if (ring_rdata !== 64'h1234) $display("FAIL rstw_rdata: got %h exp 1234", ring_rdata); else n_pass++;
        ring_req = 2'b00;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_boundary();
        logic saw_en, en_at_rdy;
        logic [63:0] en_addr, rdat;
        logic [1:0] rdy, err, rdy_after;
        int cyc;
        do_req(0, 64'h3FFFFF, 1, 64'hBEEF, saw_en, en_addr, rdy, err, rdat, cyc, en_at_rdy, rdy_after);
        n_checks++; if (en_addr !== 64'h3FFFFF) $display("FAIL bnd_top_addr: got %h exp 3fffff", en_addr); else n_pass++;
        n_checks++; if (err !== 2'b00) $display("FAIL bnd_top_err: got %b exp 00", err); else n_pass++;
        n_checks++; if (rdat !== 64'hBEEF) $display("FAIL bnd_top_rdata: got %h exp beef", rdat); else n_pass++;
        do_req(0, 64'h400000, 1, 64'h1, saw_en, en_addr, rdy, err, rdat, cyc, en_at_rdy, rdy_after);
        n_checks++; if (saw_en !== 1'b0) $display("FAIL bnd_end_rd_en: got %h exp 0", saw_en); else n_pass++;
        n_checks++; if (err !== 2'b01) $display("FAIL bnd_end_err: got %b exp 01", err); else n_pass++;
        do_req(1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h1, saw_en, en_addr, rdy, err, rdat, cyc, en_at_rdy, rdy_after);
        n_checks++; if (saw_en !== 1'b0) $display("FAIL bnd_max_rd_en: got %h exp 0", saw_en); else n_pass++;
        n_checks++; if (err !== 2'b10) $display("FAIL bnd_max_err: got %b exp 10", err); else n_pass++;

        // Shifted window on u_dut_b: [0x1000, 0x401000)
        b_addr[63:0] = 64'hFFF;
        b_req = 2'b01;
        @(negedge clk);
        n_checks++; if (b_mem_rd_en !== 1'b0) $display("FAIL bnd_b_below_rd_en: got %h exp 0", b_mem_rd_en); else n_pass++;
        @(negedge clk);
        n_checks++; if (b_err !== 2'b01) $display("FAIL bnd_b_below_err: got %b exp 01", b_err); else n_pass++;
        b_req = 2'b00;
        @(negedge clk);
        b_addr[63:0] = 64'h1000;
        b_req = 2'b01;
        @(negedge clk);
        n_checks++; if (b_mem_rd_en !== 1'b1) $display("FAIL bnd_b_base_rd_en: got %h exp 1", b_mem_rd_en); else n_pass++;
        n_checks++; if (b_mem_addr !== 64'h1000) $display("FAIL bnd_b_base_addr: got %h exp 1000", b_mem_addr); else n_pass++;
        cyc = 0;
        while (b_ready == 2'b00 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++; if (b_ready !== 2'b01) $display("FAIL bnd_b_base_ready: got %b exp 01", b_ready); else n_pass++;
        b_req = 2'b00;
        @(negedge clk);
        b_addr[63:0] = 64'h401000;
        b_req = 2'b01;
        @(negedge clk);
        n_checks++; if (b_mem_rd_en !== 1'b0) $display("FAIL bnd_b_end_rd_en: got %h exp 0", b_mem_rd_en); else n_pass++;
        @(negedge clk);
        n_checks++; if (b_err !== 2'b01) $display("FAIL bnd_b_end_err: got %b exp 01", b_err); else n_pass++;
        b_req = 2'b00;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_out_of_range();
        test_contention();
        test_timeout();
        test_reset_in_wait();
        test_boundary();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
